// File: rtl/mem_arbiter.sv
// Byte-serial arbiter for the CPU's single RAM/IO port: fetch bursts vs. LSB accesses.
// Define MEM_ARB_RR_EN for round-robin tie breaking; otherwise the LSB always wins ties.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int unsigned IF_BURST = 4,
  parameter logic [31:0] IO_BASE  = 32'h30000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_avail,
  output logic        if_word_valid,
  output logic [31:0] if_word,
  output logic        if_done,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  input  logic        rollback_in
);

  localparam logic [7:0] IF_BYTES = 8'(4 * IF_BURST);

  typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_word;
  logic [31:0] r_wdata;
  logic [7:0]  r_len;
  logic [7:0]  r_cnt;
`ifdef MEM_ARB_RR_EN
  logic        r_last_ls;
`endif

  logic        w_if_ok;
  logic        w_ls_ok;
  logic        w_pick_ls;
  logic        w_grant;
  logic [7:0]  w_ls_len;
  logic [7:0]  w_nxt;
  logic [1:0]  w_rd_lane;
  logic [31:0] w_rd_word;
  logic        w_rd_last;
  logic [7:0]  w_wr_idx;
  logic [31:0] w_wr_addr;
  logic [7:0]  w_wr_byte;
  logic        w_stall;
  logic        w_wr_last;

  // Rollback squashes speculative fetches and loads at the grant edge; stores are committed.
  always_comb begin
    w_if_ok = if_req && !rollback_in;
    w_ls_ok = ls_req && (ls_we || !rollback_in);
`ifdef MEM_ARB_RR_EN
    w_pick_ls = w_ls_ok && (!w_if_ok || !r_last_ls);
`else
    w_pick_ls = w_ls_ok;
`endif
    // A requester still holds its request during its done pulse, so no grant then.
    w_grant = !if_done && !ls_done && (w_ls_ok || w_if_ok);
    case (ls_size)
      2'b00:   w_ls_len = 8'd1;
      2'b01:   w_ls_len = 8'd2;
      default: w_ls_len = 8'd4;
    endcase
  end

  // Read pipeline: byte r_cnt-1 arrives on mem_din while address r_cnt+1 goes out.
  always_comb begin
    w_nxt     = r_cnt + 8'd1;
    w_rd_lane = r_cnt[1:0] - 2'd1;
    w_rd_last = (r_cnt == r_len);
    w_rd_word = r_word;
    case (w_rd_lane)
      2'd0:    w_rd_word[7:0]   = mem_din;
      2'd1:    w_rd_word[15:8]  = mem_din;
      2'd2:    w_rd_word[23:16] = mem_din;
      default: w_rd_word[31:24] = mem_din;
    endcase
  end

  // Write side: with mem_wr low the current byte is retried, otherwise the next one is set up.
  always_comb begin
    w_wr_idx  = mem_wr ? w_nxt : r_cnt;
    w_wr_addr = r_addr + {24'b0, w_wr_idx};
    case (w_wr_idx[1:0])
      2'd0:    w_wr_byte = r_wdata[7:0];
      2'd1:    w_wr_byte = r_wdata[15:8];
      2'd2:    w_wr_byte = r_wdata[23:16];
      default: w_wr_byte = r_wdata[31:24];
    endcase
    w_stall   = io_buffer_full && (w_wr_addr >= IO_BASE);
    w_wr_last = mem_wr && (w_nxt == r_len);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_word        <= '0;
      r_wdata       <= '0;
      r_len         <= '0;
      r_cnt         <= '0;
      mem_a         <= '0;
      mem_dout      <= '0;
      mem_wr        <= 1'b0;
      if_avail      <= 1'b1;
      if_word_valid <= 1'b0;
      if_word       <= '0;
      if_done       <= 1'b0;
      ls_done       <= 1'b0;
      ls_rdata      <= '0;
`ifdef MEM_ARB_RR_EN
      r_last_ls     <= 1'b0;
`endif
    end else if (rdy_in) begin
      if_word_valid <= 1'b0;
      if_done       <= 1'b0;
      ls_done       <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_cnt    <= '0;
            r_word   <= '0;
            if_avail <= 1'b0;
            if (w_pick_ls) begin
              r_state  <= ls_we ? LS_WR : LS_RD;
              r_addr   <= ls_addr;
              mem_a    <= ls_addr;
              r_len    <= w_ls_len;
              r_wdata  <= ls_wdata;
              mem_dout <= ls_wdata[7:0];
`ifdef MEM_ARB_RR_EN
              r_last_ls <= 1'b1;
`endif
            end else begin
              r_state <= IF_RD;
              r_addr  <= if_addr;
              mem_a   <= if_addr;
              r_len   <= IF_BYTES;
`ifdef MEM_ARB_RR_EN
              r_last_ls <= 1'b0;
`endif
            end
          end
        end
        IF_RD, LS_RD: begin
          if (rollback_in) begin
            r_state  <= IDLE;
            mem_a    <= '0;
            if_avail <= 1'b1;
          end else begin
            r_cnt <= w_nxt;
            mem_a <= (w_nxt < r_len) ? r_addr + {24'b0, w_nxt} : '0;
            if (r_cnt != 8'd0) begin
              r_word <= w_rd_word;
              if (r_state == IF_RD && w_rd_lane == 2'd3) begin
                if_word_valid <= 1'b1;
                if_word       <= w_rd_word;
              end
              if (w_rd_last) begin
                r_state  <= IDLE;
                if_avail <= 1'b1;
                if (r_state == IF_RD) begin
                  if_done <= 1'b1;
                end else begin
                  ls_done  <= 1'b1;
                  ls_rdata <= w_rd_word;
                end
              end
            end
          end
        end
        LS_WR: begin
          if (w_wr_last) begin
            r_state  <= IDLE;
            mem_wr   <= 1'b0;
            mem_a    <= '0;
            mem_dout <= '0;
            ls_done  <= 1'b1;
            if_avail <= 1'b1;
          end else begin
            r_cnt    <= w_wr_idx;
            mem_a    <= w_wr_addr;
            mem_dout <= w_wr_byte;
            mem_wr   <= !w_stall;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
